// File: rtl/ai_pkg.sv
// Shared constants, state encoding and board-index helpers for the shot requester.
package ai_pkg;

  localparam int unsigned BOARD_CELLS = 100;
  localparam int unsigned BOARD_DIM   = 10;

  localparam logic [3:0] AI_ADDR_START  = 4'd0;
  localparam logic [3:0] AI_ADDR_FIRED0 = 4'd1;
  localparam logic [3:0] AI_ADDR_FIRED1 = 4'd2;
  localparam logic [3:0] AI_ADDR_FIRED2 = 4'd3;
  localparam logic [3:0] AI_ADDR_FIRED3 = 4'd4;
  localparam logic [3:0] AI_ADDR_HITS0  = 4'd5;
  localparam logic [3:0] AI_ADDR_HITS1  = 4'd6;
  localparam logic [3:0] AI_ADDR_HITS2  = 4'd7;
  localparam logic [3:0] AI_ADDR_HITS3  = 4'd8;
  localparam logic [3:0] AI_ADDR_SHIPS  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_KICK,
    ST_ARM,
    ST_BUSY,
    ST_READ,
    ST_CAPTURE
  } ai_state_e;

  function automatic logic [3:0] cell_row(input logic [6:0] idx);
    return 4'(idx / 7'(BOARD_DIM));
  endfunction

  function automatic logic [3:0] cell_col(input logic [6:0] idx);
    return 4'(idx % 7'(BOARD_DIM));
  endfunction

  function automatic logic cell_valid(input logic [6:0] idx);
    return idx < 7'(BOARD_CELLS);
  endfunction

endpackage

// File: rtl/ai_word_pack.sv
// Maps a board snapshot and a register word address onto the 32-bit bus word
// the accelerator expects at that address; shared by the load and readback paths.
module ai_word_pack
  import ai_pkg::*;
(
  input  logic [99:0] fired_i,
  input  logic [99:0] hits_i,
  input  logic [4:0]  ships_i,
  input  logic [3:0]  ptr_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (ptr_i)
      AI_ADDR_FIRED0: word_o = fired_i[31:0];
      AI_ADDR_FIRED1: word_o = fired_i[63:32];
      AI_ADDR_FIRED2: word_o = fired_i[95:64];
      AI_ADDR_FIRED3: word_o = {28'd0, fired_i[99:96]};
      AI_ADDR_HITS0:  word_o = hits_i[31:0];
      AI_ADDR_HITS1:  word_o = hits_i[63:32];
      AI_ADDR_HITS2:  word_o = hits_i[95:64];
      AI_ADDR_HITS3:  word_o = {28'd0, hits_i[99:96]};
      AI_ADDR_SHIPS:  word_o = {27'd0, ships_i};
      default:        word_o = '0;
    endcase
  end

endmodule

// File: rtl/ai_shot_requester.sv
// Bus master that loads the board snapshot into the density accelerator, kicks it and fetches the chosen cell.
// Define AI_READBACK_CHECK_EN to read back and verify every loaded word before the kick.
module ai_shot_requester
  import ai_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8192,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [99:0] fired,
  input  logic [99:0] hits,
  input  logic [4:0]  ships,
  output logic [3:0]  addr,
  output logic        write_en,
  output logic        read_en,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  input  logic        wait_request,
  output logic        busy,
  output logic        done,
  output logic [6:0]  shot_index,
  output logic [3:0]  shot_row,
  output logic [3:0]  shot_col,
  output logic        err
);

  // READ_LATENCY must be at least 1: rd_data is sampled in the cycles after the accepted read.
  localparam int unsigned  TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned  LW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(READ_LATENCY - 1);

  ai_state_e     state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [99:0]   fired_q, fired_d;
  logic [99:0]   hits_q, hits_d;
  logic [4:0]    ships_q, ships_d;
  logic [3:0]    addr_q, addr_d;
  logic          write_en_q, write_en_d;
  logic          read_en_q, read_en_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [6:0]    idx_q, idx_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic          err_q, err_d;

  logic [99:0]   snap_fired;
  logic [99:0]   snap_hits;
  logic [4:0]    snap_ships;
  logic [3:0]    pack_ptr;
  logic [31:0]   pack_word;
  logic          timed;
  logic          progress;
  logic          abort;

  // The packer sees the word that will be on the bus next cycle, so in IDLE it
  // must look at the live inputs that are being captured on this same edge.
  always_comb begin
    snap_fired = fired_q;
    snap_hits  = hits_q;
    snap_ships = ships_q;
    pack_ptr   = ptr_q;
    if (state_q == ST_IDLE) begin
      snap_fired = fired;
      snap_hits  = hits;
      snap_ships = ships;
      pack_ptr   = AI_ADDR_FIRED0;
    end else if (state_q == ST_LOAD && write_en_q && !wait_request) begin
      pack_ptr = ptr_q + 4'd1;
    end
  end

  ai_word_pack u_pack (
    .fired_i (snap_fired),
    .hits_i  (snap_hits),
    .ships_i (snap_ships),
    .ptr_i   (pack_ptr),
    .word_o  (pack_word)
  );

  assign timed = (state_q == ST_LOAD)  || (state_q == ST_VERIFY) ||
                 (state_q == ST_KICK)  || (state_q == ST_ARM)    ||
                 (state_q == ST_BUSY)  || (state_q == ST_READ);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lat_d      = lat_q;
    fired_d    = fired_q;
    hits_d     = hits_q;
    ships_d    = ships_q;
    addr_d     = addr_q;
    write_en_d = write_en_q;
    read_en_d  = read_en_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    err_d      = err_q;
    progress   = 1'b0;
    abort      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          progress   = 1'b1;
          fired_d    = snap_fired;
          hits_d     = snap_hits;
          ships_d    = snap_ships;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          ptr_d      = AI_ADDR_FIRED0;
          addr_d     = AI_ADDR_FIRED0;
          write_en_d = 1'b1;
          wr_data_d  = pack_word;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (write_en_q && !wait_request) begin
          progress = 1'b1;
          if (ptr_q == AI_ADDR_SHIPS) begin
`ifdef AI_READBACK_CHECK_EN
            write_en_d = 1'b0;
            read_en_d  = 1'b1;
            ptr_d      = AI_ADDR_FIRED0;
            addr_d     = AI_ADDR_FIRED0;
            state_d    = ST_VERIFY;
`else
            addr_d     = AI_ADDR_START;
            wr_data_d  = '0;
            state_d    = ST_KICK;
`endif
          end else begin
            ptr_d     = ptr_q + 4'd1;
            addr_d    = ptr_q + 4'd1;
            wr_data_d = pack_word;
          end
        end
      end

`ifdef AI_READBACK_CHECK_EN
      // Each word: one accepted read cycle, then READ_LATENCY cycles until its data arrives.
      ST_VERIFY: begin
        if (read_en_q) begin
          if (!wait_request) begin
            progress  = 1'b1;
            read_en_d = 1'b0;
            lat_d     = '0;
          end
        end else if (lat_q == LAT_LAST) begin
          progress = 1'b1;
          if (rd_data != pack_word) begin
            abort = 1'b1;
          end else if (ptr_q == AI_ADDR_SHIPS) begin
            write_en_d = 1'b1;
            addr_d     = AI_ADDR_START;
            wr_data_d  = '0;
            state_d    = ST_KICK;
          end else begin
            ptr_d     = ptr_q + 4'd1;
            addr_d    = ptr_q + 4'd1;
            read_en_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
`endif

      ST_KICK: begin
        if (write_en_q && !wait_request) begin
          progress   = 1'b1;
          write_en_d = 1'b0;
          state_d    = ST_ARM;
        end
      end

      ST_ARM: begin
        if (wait_request) begin
          progress = 1'b1;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (!wait_request) begin
          progress  = 1'b1;
          read_en_d = 1'b1;
          addr_d    = AI_ADDR_START;
          state_d   = ST_READ;
        end
      end

      ST_READ: begin
        if (read_en_q && !wait_request) begin
          progress  = 1'b1;
          read_en_d = 1'b0;
          lat_d     = '0;
          state_d   = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (lat_q == LAT_LAST) begin
          idx_d   = rd_data[6:0];
          row_d   = cell_row(rd_data[6:0]);
          col_d   = cell_col(rd_data[6:0]);
          err_d   = err_q | !cell_valid(rd_data[6:0]);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (timed && !progress && timer_q == TIMER_LAST) begin
      abort = 1'b1;
    end

    if (abort) begin
      write_en_d = 1'b0;
      read_en_d  = 1'b0;
      addr_d     = '0;
      wr_data_d  = '0;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      state_d    = ST_IDLE;
    end

    // Every completed transfer or state change opens a fresh timeout window.
    timer_d = (progress || !timed) ? '0 : timer_q + 1'b1;
  end

`ifndef AI_READBACK_CHECK_EN
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_data[31:7];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      lat_q      <= '0;
      fired_q    <= '0;
      hits_q     <= '0;
      ships_q    <= '0;
      addr_q     <= '0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      lat_q      <= lat_d;
      fired_q    <= fired_d;
      hits_q     <= hits_d;
      ships_q    <= ships_d;
      addr_q     <= addr_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
    end
  end

  assign addr       = addr_q;
  assign write_en   = write_en_q;
  assign read_en    = read_en_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign shot_index = idx_q;
  assign shot_row   = row_q;
  assign shot_col   = col_q;
  assign err        = err_q;

endmodule

// File: doc/ai_shot_requester.md
# ai_shot_requester

Avalon-MM-style bus master that drives the density-targeting accelerator from the game-logic side. On a `start` pulse it snapshots the fired/hits/ships board state, writes it into the accelerator's register map, kicks a computation, waits out `wait_request`, reads back the chosen cell index, and returns it as index plus row/column with a one-cycle `done` pulse. It sits between the game controller FSM and the accelerator's slave port.

## Interface
- `TIMEOUT_CYCLES`, default 8192: max cycles any single bus phase may stall before abort with `err`.
- `READ_LATENCY`, default 1: cycles from the read_en cycle to valid `rd_data`.
- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a shot; sampled only in IDLE.
- `fired`  in  100  cells already shot (bit = row*10+col).
- `hits`  in  100  cells shot and hit.
- `ships`  in  5  ships still afloat, bit i = ship i.
- `addr`  out  4  bus word address.
- `write_en`  out  1  bus write strobe.
- `read_en`  out  1  bus read strobe.
- `wr_data`  out  32  bus write data.
- `rd_data`  in  32  bus read data.
- `wait_request`  in  1  slave busy / stall.
- `busy`  out  1  high from accepted start until done/err.
- `done`  out  1  one-cycle pulse, result valid.
- `shot_index`  out  7  chosen cell, 0–99.
- `shot_row`, `shot_col`  out  4 each  shot_index/10, shot_index%10.
- `err`  out  1  sticky until next accepted start; timeout (or readback mismatch).

## Operation
- Register map: 0 start(write)/result(read); 1–3 fired[31:0],[63:32],[95:64]; 4 {28'0,fired[99:96]}; 5–8 same for hits; 9 {27'0,ships}.
- States: IDLE → LOAD → KICK → ARM → BUSY → READ → CAPTURE → IDLE.
- IDLE: on `start`, latch fired/hits/ships into snapshot regs, clear err, set busy, word ptr=1, go LOAD.
- LOAD: write_en=1, addr=ptr, wr_data=packed word. Transfer completes on a cycle with write_en=1 and wait_request=0; then ptr+1. After ptr 9 completes → KICK.
- KICK: write addr 0, data 0; on completion → ARM.
- ARM: wait for wait_request=1 (accelerator started) → BUSY.
- BUSY: wait for wait_request=0 → READ.
- READ: read_en=1, addr 0 for one accepted cycle (held while wait_request=1) → CAPTURE.
- CAPTURE: after READ_LATENCY cycles sample rd_data[6:0] into shot_index, compute row/col, pulse done, clear busy → IDLE.
- addr/wr_data/strobes stay stable while wait_request=1; strobes low in IDLE, ARM, BUSY, CAPTURE.
- Timeout: per-phase counter reset on each state entry; reaching TIMEOUT_CYCLES in LOAD/KICK/ARM/BUSY/READ → drop strobes, err=1, busy=0, no done, → IDLE.
- `start` while busy ignored; snapshot inputs may change freely after acceptance.
- shot_index > 99 from bus: err=1, done still pulses, index passed through unmodified.

## Timing
- Reset: state IDLE; addr 0, write_en 0, read_en 0, wr_data 0, busy 0, done 0, shot_index 0, shot_row 0, shot_col 0, err 0.
- All outputs registered. start in cycle 0 → first write visible cycle 1; with no stalls, words 1–9 in cycles 1–9, kick in cycle 10, ARM cycle 11.
- wait_request low observed in cycle N (BUSY) → read_en in N+1 → done and shot_index visible in N+2+READ_LATENCY.
- Each stalled cycle extends the current phase by exactly one cycle.
- Reset mid-operation: immediate return to reset values, partial bus transfer abandoned.

## Configuration
- `AI_READBACK_CHECK_EN` defined: VERIFY state inserted between LOAD and KICK; reads addr 1–9, compares to snapshot (word 4/8 upper bits must be 0); any mismatch → err=1, busy=0, → IDLE, no kick. Adds 9×(1+READ_LATENCY) cycles minimum.
- Undefined: no VERIFY state, LOAD goes straight to KICK.

## Structure
- Shared package `ai_pkg`: address constants AI_ADDR_START..AI_ADDR_SHIPS (0–9), BOARD_CELLS=100, BOARD_DIM=10, requester state enum.
- Sub-module `ai_word_pack`: combinational snapshot + ptr → 32-bit word, reused by LOAD and VERIFY.

## Test plan
- Empty board, ships=5'h1F, slave model busy 300 cycles returning 44 → 9 writes then kick with values above, done at N+3, shot_index=44, row 4, col 4.
- Stalls of 2 cycles on words 3 and 7 → addr/wr_data stable during stalls, total LOAD time 13 cycles, correct values.
- Slave never releases wait_request in BUSY with TIMEOUT_CYCLES=64 → err=1 after 64 cycles, busy=0, no done.
- start pulsed again mid-BUSY, then reset_n low for 1 cycle mid-LOAD → second start ignored; after reset all outputs 0, state IDLE, new start runs cleanly.
- Slave returns 127 → done pulses, err=1, shot_index=127.
- With AI_READBACK_CHECK_EN, slave corrupts hits[63:32] readback → err=1, no write to addr 0.
